// File: rtl/freq_meas_ctrl.sv
// Command sequencer for the reciprocal counter: gates, latches counts, streams an 11-byte snapshot over SPI.
// Latency: gate_en rises 1 cycle after a start, tx_dv 1 cycle after each rx_dv; no backpressure (SPI paces reads).
// Optional: FREQ_CTRL_TIMEOUT_EN adds a cnt_done watchdog in WAIT_DONE.
module freq_meas_ctrl #(
   parameter int CNT_W          = 34,
   parameter int GATE_CYCLES    = 27000000,
   parameter int HOLDOFF_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 54000000
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   output logic             gate_en,
   input  logic             cnt_done,
   input  logic [CNT_W-1:0] stand_cnt,
   input  logic [CNT_W-1:0] test_cnt,
   input  logic             rx_dv,
   input  logic [7:0]       rx_byte,
   output logic             tx_dv,
   output logic [7:0]       tx_byte,
   output logic             busy,
   output logic             result_valid
);

   localparam int MAXA = (GATE_CYCLES > HOLDOFF_CYCLES) ? GATE_CYCLES : HOLDOFF_CYCLES;
`ifdef FREQ_CTRL_TIMEOUT_EN
   localparam int MAXC = (MAXA > TIMEOUT_CYCLES) ? MAXA : TIMEOUT_CYCLES;
`else
   localparam int MAXC = (TIMEOUT_CYCLES > 0) ? MAXA : MAXA;
`endif
   localparam int CW = $clog2(MAXC + 1);

   typedef enum logic [2:0] {S_IDLE, S_GATE, S_WAIT, S_LATCH, S_HOLD} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             cmd_vld, snap, start_cmd, cont_nxt, latch_evt;
   logic             cont_mode, overrun, timeout_err, unread, rd_active;
   logic [CNT_W-1:0] res_stand, res_test;
   logic [3:0]       ptr, ptr_inc;
   logic [7:0]       shadow [0:10];
   logic [7:0]       status;
   logic [39:0]      stand_ext, test_ext;
`ifdef FREQ_CTRL_TIMEOUT_EN
   logic             timeout_evt;
`endif

   // bytes arriving during a read stream are dummies and never decoded
   assign cmd_vld   = rx_dv & ~rd_active;
   assign snap      = cmd_vld && (rx_byte == 8'h10);
   assign start_cmd = cmd_vld && ((rx_byte == 8'h01) || (rx_byte == 8'h02));
   assign busy      = (state == S_GATE) || (state == S_WAIT);
   assign status    = {4'b0000, timeout_err, overrun, cont_mode, result_valid};
   assign stand_ext = 40'(res_stand);
   assign test_ext  = 40'(res_test);
   assign ptr_inc   = ptr + 4'd1;

   always_comb begin
      cont_nxt = cont_mode;
      if (cmd_vld && (rx_byte == 8'h02))
         cont_nxt = 1'b1;
      else if (cmd_vld && (rx_byte == 8'h03))
         cont_nxt = 1'b0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      latch_evt = 1'b0;
`ifdef FREQ_CTRL_TIMEOUT_EN
      timeout_evt = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start_cmd)
               state_nxt = S_GATE;
         end
         S_GATE: begin
            if (cnt == CW'(GATE_CYCLES - 1)) begin
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
            end
         end
         S_WAIT: begin
            if (cnt_done) begin
               state_nxt = S_LATCH;
               cnt_nxt   = '0;
            end
`ifdef FREQ_CTRL_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               timeout_evt = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = cont_nxt ? S_HOLD : S_IDLE;
            end
`else
            else
               cnt_nxt = '0;
`endif
         end
         S_LATCH: begin
            latch_evt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = cont_nxt ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (!cont_nxt) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CW'(HOLDOFF_CYCLES - 1)) begin
               state_nxt = S_GATE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         gate_en      <= 1'b0;
         result_valid <= 1'b0;
         cont_mode    <= 1'b0;
         overrun      <= 1'b0;
         unread       <= 1'b0;
         rd_active    <= 1'b0;
         ptr          <= 4'd0;
         tx_dv        <= 1'b0;
         tx_byte      <= 8'h00;
         res_stand    <= '0;
         res_test     <= '0;
      end else begin
         gate_en   <= (state_nxt == S_GATE);
         cont_mode <= cont_nxt;
         tx_dv     <= 1'b0;
         if (latch_evt) begin
            res_stand    <= stand_cnt;
            res_test     <= test_cnt;
            result_valid <= 1'b1;
         end
         // a snapshot coincident with LATCH reads the old result, so the new one is unread
         unread  <= latch_evt | (unread & ~snap);
         overrun <= ~snap & (overrun | (latch_evt & unread));
         if (snap) begin
            ptr       <= 4'd0;
            rd_active <= 1'b1;
            tx_dv     <= 1'b1;
            tx_byte   <= status;
         end else if (rx_dv && rd_active) begin
            tx_dv <= 1'b1;
            if (ptr == 4'd10) begin
               rd_active <= 1'b0;
               tx_byte   <= 8'h00;
            end else begin
               ptr     <= ptr_inc;
               tx_byte <= shadow[ptr_inc];
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (snap) begin
         shadow[0]  <= status;
         shadow[1]  <= stand_ext[39:32];
         shadow[2]  <= stand_ext[31:24];
         shadow[3]  <= stand_ext[23:16];
         shadow[4]  <= stand_ext[15:8];
         shadow[5]  <= stand_ext[7:0];
         shadow[6]  <= test_ext[39:32];
         shadow[7]  <= test_ext[31:24];
         shadow[8]  <= test_ext[23:16];
         shadow[9]  <= test_ext[15:8];
         shadow[10] <= test_ext[7:0];
      end
   end

`ifdef FREQ_CTRL_TIMEOUT_EN
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         timeout_err <= 1'b0;
      else
         timeout_err <= (timeout_err & ~snap) | timeout_evt;
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Randomized scoreboard bench for freq_meas_ctrl: a result/status model predicts every streamed byte.
module tb_freq_meas_ctrl;
   localparam int CNT_W = 34;
   localparam int GATE  = 100;
   localparam int HOLD  = 4;
   localparam int TMO   = 50;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             gate_en;
   logic             cnt_done = 1'b0;
   logic [CNT_W-1:0] stand_cnt = '0;
   logic [CNT_W-1:0] test_cnt = '0;
   logic             rx_dv = 1'b0;
   logic [7:0]       rx_byte = 8'h00;
   logic             tx_dv;
   logic [7:0]       tx_byte;
   logic             busy;
   logic             result_valid;

   freq_meas_ctrl #(
      .CNT_W(CNT_W), .GATE_CYCLES(GATE), .HOLDOFF_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .gate_en(gate_en), .cnt_done(cnt_done),
      .stand_cnt(stand_cnt), .test_cnt(test_cnt), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .tx_dv(tx_dv), .tx_byte(tx_byte), .busy(busy), .result_valid(result_valid)
   );

   always #5 sys_clk = ~sys_clk;

   int         nvec = 0;
   int         nerr = 0;
   logic [7:0] exp_tx [$];
   int         gate_run = 0;
   bit         gate_abort = 0;

   // reference model: what the host should see
   logic [CNT_W-1:0] m_s, m_t;
   bit               m_rv, m_cont, m_ovr, m_tmo, m_unread;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge sys_clk);
      if (gate_abort)
         gate_run = 0;
      else if (gate_en)
         gate_run++;
      else if (gate_run != 0) begin
         chk("gate_len", 64'(gate_run), 64'(GATE));
         gate_run = 0;
      end
      if (tx_dv) begin
         if (exp_tx.size() == 0)
            chk("tx_unexpected", 64'(tx_dv), 64'd0);
         else
            chk("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares", nvec, nerr);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_dv   = 1'b1;
      rx_byte = b;
      tick();
      rx_dv   = 1'b0;
   endtask

   task automatic model_reset();
      m_s = '0; m_t = '0;
      m_rv = 0; m_cont = 0; m_ovr = 0; m_tmo = 0; m_unread = 0;
   endtask

   task automatic model_latch(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] t);
      if (m_unread) m_ovr = 1;
      m_unread = 1;
      m_s = s; m_t = t; m_rv = 1;
   endtask

   task automatic push_read();
      logic [39:0] s40, t40;
      s40 = 40'(m_s);
      t40 = 40'(m_t);
      exp_tx.push_back({4'b0000, m_tmo, m_ovr, m_cont, m_rv});
      for (int i = 4; i >= 0; i--) exp_tx.push_back(8'((s40 >> (8 * i)) & 40'hFF));
      for (int i = 4; i >= 0; i--) exp_tx.push_back(8'((t40 >> (8 * i)) & 40'hFF));
      exp_tx.push_back(8'h00);
      m_ovr = 0; m_tmo = 0; m_unread = 0;
   endtask

   task automatic read_stream(input bit lat, input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] t);
      push_read();
      if (lat) model_latch(s, t);
      send(8'h10);
      for (int i = 0; i < 11; i++) begin
         repeat ($urandom_range(3, 0)) tick();
         send(8'($urandom_range(255, 0)));
      end
      repeat (3) tick();
      chk("stream_drain", 64'(exp_tx.size()), 64'd0);
   endtask

   task automatic wait_gate_fall();
      int n = 0;
      while (gate_en && n < GATE + 20) begin tick(); n++; end
      chk("gate_fall", 64'(gate_en), 64'd0);
   endtask

   task automatic do_meas(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] t, input bit coincide);
      wait_gate_fall();
      repeat ($urandom_range(5, 0)) tick();
      stand_cnt = s; test_cnt = t; cnt_done = 1'b1;
      tick();
      cnt_done = 1'b0;
      if (coincide) read_stream(1, s, t);
      else model_latch(s, t);
   endtask

   task automatic holdoff_chk();
      int n = 0;
      while (!gate_en && n < 20) begin tick(); n++; end
      chk("holdoff_gap", 64'(n), 64'(1 + HOLD));
   endtask

   function automatic logic [CNT_W-1:0] rnd_cnt();
      return CNT_W'({$urandom(), $urandom()});
   endfunction

   initial begin
      model_reset();
      repeat (3) tick();
      chk("rst_gate_en", 64'(gate_en), 64'd0);
      chk("rst_tx_dv", 64'(tx_dv), 64'd0);
      chk("rst_tx_byte", 64'(tx_byte), 64'h00);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result_valid", 64'(result_valid), 64'd0);
      sys_rst = 1'b0;
      tick();

      send(8'h55);
      send(8'h03);
      repeat (3) tick();
      chk("idle_gate_en", 64'(gate_en), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      stand_cnt = rnd_cnt(); test_cnt = rnd_cnt(); cnt_done = 1'b1;
      tick();
      cnt_done = 1'b0;
      tick();
      chk("stray_done_rv", 64'(result_valid), 64'd0);
      read_stream(0, '0, '0);

      send(8'h01);
      chk("start_gate_en", 64'(gate_en), 64'd1);
      chk("start_busy", 64'(busy), 64'd1);
      repeat (10) tick();
      send(8'h01);
      do_meas(34'h2_0000_0001, 34'h0_0000_1234, 0);
      tick();
      chk("single_rv", 64'(result_valid), 64'd1);
      chk("single_busy", 64'(busy), 64'd0);
      read_stream(0, '0, '0);

      for (int k = 0; k < 4; k++) begin
         send(8'h01);
         chk("loop_gate_en", 64'(gate_en), 64'd1);
         do_meas(rnd_cnt(), rnd_cnt(), 0);
         tick();
         if ($urandom_range(1, 0) == 1) read_stream(0, '0, '0);
      end

      send(8'h02);
      m_cont = 1;
      chk("cont_gate_en", 64'(gate_en), 64'd1);
      do_meas(rnd_cnt(), rnd_cnt(), 0);
      holdoff_chk();
      do_meas(rnd_cnt(), rnd_cnt(), 0);
      holdoff_chk();
      read_stream(0, '0, '0);
      do_meas(rnd_cnt(), rnd_cnt(), 0);
      holdoff_chk();
      read_stream(0, '0, '0);
      send(8'h03);
      m_cont = 0;
      chk("stop_still_busy", 64'(busy), 64'd1);
      do_meas(rnd_cnt(), rnd_cnt(), 0);
      tick();
      chk("stop_busy", 64'(busy), 64'd0);
      repeat (10) tick();
      chk("stop_no_regate", 64'(gate_en), 64'd0);
      read_stream(0, '0, '0);

      send(8'h01);
      do_meas(rnd_cnt(), rnd_cnt(), 1);
      tick();
      read_stream(0, '0, '0);

`ifdef FREQ_CTRL_TIMEOUT_EN
      begin
         int n = 0;
         send(8'h01);
         wait_gate_fall();
         while (busy && n < TMO + 20) begin tick(); n++; end
         chk("timeout_len", 64'(n), 64'(TMO));
         chk("timeout_rv", 64'(result_valid), 64'(m_rv));
         m_tmo = 1;
         tick();
         read_stream(0, '0, '0);
      end
`endif

      send(8'h01);
      repeat (10) tick();
      gate_abort = 1;
      sys_rst = 1'b1;
      #1;
      chk("rst_async_gate_en", 64'(gate_en), 64'd0);
      chk("rst_async_busy", 64'(busy), 64'd0);
      tick();
      tick();
      sys_rst = 1'b0;
      model_reset();
      exp_tx.delete();
      tick();
      gate_abort = 0;
      chk("post_rst_rv", 64'(result_valid), 64'd0);
      read_stream(0, '0, '0);

      repeat (5) tick();
      chk("final_drain", 64'(exp_tx.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
